// File: rtl/truth_table_sweeper.sv
// Sequencer that sweeps a 4-input function block through all 16 input combinations,
// captures its truth table and compares it against an expected constant.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 3,
  parameter logic [15:0] EXPECTED      = 16'hA5C3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        F,
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [15:0] tbl, tbl_nx;
  logic [4:0]  mm, mm_nx;
  logic [3:0]  ff, ff_nx;
  logic        pass_r, pass_nx;
  logic        mismatch;

  assign mismatch = (F != EXPECTED[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      tbl    <= '0;
      mm     <= '0;
      ff     <= '0;
      pass_r <= 1'b0;
    end else begin
      state  <= state_nx;
      idx    <= idx_nx;
      cnt    <= cnt_nx;
      tbl    <= tbl_nx;
      mm     <= mm_nx;
      ff     <= ff_nx;
      pass_r <= pass_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt;
    tbl_nx   = tbl;
    mm_nx    = mm;
    ff_nx    = ff;
    pass_nx  = pass_r;
    case (state)
      IDLE, DONE: begin
        // abort outranks start even where it otherwise has no effect
        if (start && !abort) begin
          state_nx = SETTLE;
          idx_nx   = '0;
          cnt_nx   = CNT_LOAD;
          tbl_nx   = '0;
          mm_nx    = '0;
          ff_nx    = '0;
          pass_nx  = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else if (cnt != '0) begin
          cnt_nx = cnt - 8'd1;
        end else begin
          state_nx = SAMPLE;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_nx = IDLE;
          idx_nx   = '0;
        end else begin
          tbl_nx[idx] = F;
          if (mismatch) begin
            mm_nx = mm + 5'd1;
            if (mm == '0) ff_nx = idx;
          end
          if (idx == 4'd15) begin
            state_nx = DONE;
            pass_nx  = (mm_nx == '0);
          end else begin
            state_nx = SETTLE;
            idx_nx   = idx + 4'd1;
            cnt_nx   = CNT_LOAD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign {A, B, C, D}  = idx;
  assign busy          = (state == SETTLE) || (state == SAMPLE);
  assign done          = (state == DONE);
  assign pass          = pass_r;
  assign table_out     = tbl;
  assign mismatch_cnt  = mm;
  assign first_fail    = ff;

endmodule
